// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
//
// Takes the execute-stage bundle and does one of three things:
//   * non-memory ops: registers the result into the MEM/WB bundle (1 cycle).
//   * legal loads/stores: runs a request/response handshake on the
//     single-ported data memory while stalling upstream.
//   * illegal or misaligned accesses: raises a one-cycle fault and emits
//     a writeback bundle with the register write suppressed.
//
// Ports
//   clk, i_rst            clock / async active-low reset
//   i_valid .. i_funct3   execute-stage bundle
//   o_stall               upstream must hold its bundle
//   o_dmem_*              data-memory request (addr word aligned, byte mask,
//                         lane-replicated write data)
//   i_dmem_*              memory accept / load-data return
//   o_wb_*                MEM/WB bundle (o_wb_data also feeds prev_mem forwarding)
//   o_mem_fault           one-cycle pulse: illegal funct3, misalignment, timeout
//
// TIMEOUT_CYCLES: waiting cycles in REQ or RESP before faulting (0 = never).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_ex_result,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd_addr,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_reg_write,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_data,
    output logic        o_mem_fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

    state_t      r_state, w_state_nxt;

    // Transaction latched on acceptance
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_is_load;
    logic [31:0] r_cnt;

    // MEM/WB registers
    logic        r_wb_valid;
    logic        r_wb_reg_write;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_data;
    logic        r_fault;

    // Accept-side decode
    logic        w_is_mem, w_f3_legal, w_misalign;
    logic        w_ex_alu, w_ex_go, w_ex_fault;
    // Transaction events
    logic        w_st_done, w_ld_issue, w_ld_done, w_tmo, w_to_hit;
    // Datapath
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_rshift;
    logic [31:0] w_ldata;

    always_comb begin
        w_is_mem   = i_mem_read | i_mem_write;
        w_f3_legal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = i_mem_read;  // unsigned forms exist only for loads
            default:                w_f3_legal = 1'b0;
        endcase
        w_misalign = ((i_funct3[1:0] == 2'b01) && i_ex_result[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_ex_result[1:0] != 2'b00));
        w_ex_alu   = (r_state == ST_IDLE) && i_valid && !w_is_mem;
        w_ex_go    = (r_state == ST_IDLE) && i_valid && w_is_mem && w_f3_legal && !w_misalign;
        w_ex_fault = (r_state == ST_IDLE) && i_valid && w_is_mem && !(w_f3_legal && !w_misalign);
    end

    // r_cnt counts completed waiting cycles, so the hit fires on the
    // TIMEOUT_CYCLES-th waiting cycle.
    assign w_to_hit = (TIMEOUT_CYCLES > 0) && (r_cnt == TO_LIMIT - 32'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_st_done   = 1'b0;
        w_ld_issue  = 1'b0;
        w_ld_done   = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ex_go) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (i_dmem_ready) begin
                    if (r_is_load) begin
                        w_ld_issue  = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_st_done   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (i_dmem_rvalid) begin
                    w_ld_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_to_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane enables and replicated write data (same lane pattern for loads).
    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = r_sdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_mask  = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = r_sdata;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend.
    assign w_rshift = i_dmem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ldata = i_dmem_rdata;
        case (r_funct3)
            3'b000:  w_ldata = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_ldata = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_ldata = {24'd0, w_rshift[7:0]};
            3'b101:  w_ldata = {16'd0, w_rshift[15:0]};
            default: w_ldata = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr         <= '0;
            r_sdata        <= '0;
            r_funct3       <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_is_load      <= 1'b0;
            r_cnt          <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd_addr   <= '0;
            r_wb_data      <= '0;
            r_fault        <= 1'b0;
        end else begin
            if (w_ex_go) begin
                r_addr      <= i_ex_result;
                r_sdata     <= i_store_data;
                r_funct3    <= i_funct3;
                r_rd        <= i_rd_addr;
                r_reg_write <= i_reg_write;
                r_is_load   <= i_mem_read;  // read wins when both are set
            end

            if (w_ex_go || w_ld_issue)  r_cnt <= '0;
            else if (r_state != ST_IDLE) r_cnt <= r_cnt + 32'd1;

            r_wb_valid <= w_ex_alu | w_ex_fault | w_st_done | w_ld_done | w_tmo;
            r_fault    <= w_ex_fault | w_tmo;

            // rd/data hold across bubbles so the forwarding source stays stable.
            if (w_ex_alu) begin
                r_wb_reg_write <= i_reg_write;
                r_wb_rd_addr   <= i_rd_addr;
                r_wb_data      <= i_ex_result;
            end else if (w_ld_done) begin
                r_wb_reg_write <= r_reg_write;
                r_wb_rd_addr   <= r_rd;
                r_wb_data      <= w_ldata;
            end else if (w_ex_fault) begin
                r_wb_reg_write <= 1'b0;
                r_wb_rd_addr   <= i_rd_addr;
                r_wb_data      <= '0;
            end else if (w_st_done || w_tmo) begin
                r_wb_reg_write <= 1'b0;
                r_wb_rd_addr   <= r_rd;
                r_wb_data      <= '0;
            end else begin
                r_wb_reg_write <= 1'b0;
            end
        end
    end

    assign o_stall        = (r_state != ST_IDLE);
    assign o_dmem_req     = (r_state == ST_REQ);
    assign o_dmem_wen     = o_dmem_req && !r_is_load;
    assign o_dmem_addr    = o_dmem_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_dmem_mask    = o_dmem_req ? w_mask : 4'd0;
    assign o_dmem_wdata   = o_dmem_wen ? w_wdata : 32'd0;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_rd_addr   = r_wb_rd_addr;
    assign o_wb_data      = r_wb_data;
    assign o_mem_fault    = r_fault;

endmodule
